io_tile_gen2: RTL and testbench
===============================

Name: io_tile_gen2

Overview:
- Parametrised next-generation IO tile.
- Combines the tile's configuration scan chain and its IO/interconnect routing crossbar in one single-clock block.
- Adds double-buffered configuration: shift, then explicit commit with a bit-count check.
- Adds a per-route output register option and a per-pin output-enable.
- Instantiated on every perimeter edge of the fabric; tiles are daisy-chained through config_in/config_out.

Parameters:
- IO_COUNT, 4, number of physical IO pins.
- IC_COUNT, 6, number of interconnect wires.
- SEL_IC, clog2(IC_COUNT) (derived, 3), selector width for to-io routes.
- SEL_IO, clog2(IO_COUNT) (derived, 2), selector width for to-ic routes.
- CONFIG_WIDTH, IO_COUNT*(SEL_IC+2)+IC_COUNT*(SEL_IO+1) (derived, 38), config chain length.

Ports:
- clock  in  1  sole clock; config and data paths both use it.
- reset  in  1  synchronous, active-high reset.
- config_in  in  1  serial config bit.
- config_out  out  1  shift_reg[CONFIG_WIDTH-1], feeds the next tile.
- config_enable  in  1  shift one bit this cycle.
- config_commit  in  1  request copy of shift register into active config.
- config_valid  out  1  active config holds a committed frame.
- config_error  out  1  last commit was rejected.
- data_from_io  in  IO_COUNT  pad inputs.
- data_to_io  out  IO_COUNT  pad outputs.
- data_to_io_oe  out  IO_COUNT  pad output enables.
- data_from_ic  in  IC_COUNT  interconnect inputs.
- data_to_ic  out  IC_COUNT  interconnect outputs.

Behaviour:
- Reset (synchronous, active-high):
  - shift_reg, active_cfg, bit_cnt and all route flops clear to 0.
  - config_valid=0, config_error=0; all data outputs 0.
  - Reset asserted mid-shift discards the partial frame.
- Shift: when config_enable=1, shift_reg <= {shift_reg[W-2:0], config_in}.
  - bit_cnt increments and saturates at W+1; counter width clog2(W+2).
- Commit (config_commit=1, config_enable=0):
  - bit_cnt==W: active_cfg <= shift_reg, config_valid<=1, config_error<=0.
  - Otherwise (short, or long/saturated): active_cfg unchanged, config_error<=1, config_valid unchanged.
  - bit_cnt<=0 in both cases.
- Commit and enable in the same cycle:
  - Commit rejected: config_error<=1, active_cfg unchanged.
  - Shift still performed; bit_cnt<=1.
- Shifting never disturbs active_cfg, so routing stays live during reconfiguration.
- active_cfg field layout, LSB first:
  - Pin i at offset i*(SEL_IC+2): sel[SEL_IC], reg, oe.
  - Then wire j at offset IO_COUNT*(SEL_IC+2)+j*(SEL_IO+1): sel[SEL_IO], reg.
- Routing:
  - to-io mux output = data_from_ic[sel].
  - to-ic mux output = data_from_io[sel].
  - sel >= source count drives 0.
- Route register bit:
  - reg=0: output is combinational from the mux (0-cycle latency).
  - reg=1: output taken from a flop that samples the mux every clock (1-cycle latency).
  - Route flops sample unconditionally, regardless of the reg bit.
- data_to_io_oe[i] = oe bit of pin i.
- While config_valid=0, data_to_io, data_to_io_oe and data_to_ic are forced to 0.
- New config after a commit:
  - Takes effect on combinational paths in the cycle after the commit edge.
  - Registered paths show the new routing one cycle later.
- config_out is always shift_reg MSB; it does not depend on commit state.

Decomposition:
- Package io_tile_pkg:
  - clog2 function.
  - Derived width constants SEL_IC, SEL_IO, CONFIG_WIDTH.
  - Field offset functions pin_offset(i) and wire_offset(j).
- Sub-module io_tile_config_chain: owns shift_reg, bit_cnt, active_cfg, commit/error logic.
- Crossbar and route flops stay in io_tile_gen2 as generate loops.

Test Plan:
- Reset check: after reset, drive all inputs to 1 -> every output 0; config_valid=0, config_error=0.
- Valid frame with default parameters:
  - Shift 38 bits with pin0 sel=2, reg=0, oe=1; commit.
  - Next cycle config_valid=1.
  - data_from_ic=6'b000100 -> data_to_io[0]=1, data_to_io_oe[0]=1, same cycle.
- Short and long frames:
  - 37 shifts then commit -> config_error=1, routing unchanged.
  - 40 shifts then commit -> config_error=1, routing unchanged.
  - A following correct 38-bit frame clears config_error.
- Registered path:
  - wire3 sel=1, reg=1; toggle data_from_io[1] 0->1 -> data_to_ic[3] rises exactly 1 cycle later.
  - Out-of-range pin sel=7 -> data_to_io=0.
- Commit with config_enable in the same cycle -> config_error=1, shift performed, bit_cnt=1.
  - Then 37 more shifts and a commit -> accepted.
- Chaining and mid-shift reset:
  - Two instances chained, 76 shifts, one commit on each -> both configs correct.
  - config_out equals config_in delayed 38 enabled shifts.
  - Reset asserted after 20 shifts -> shift_reg=0, bit_cnt=0.

Source files
------------

// File: rtl/io_tile_pkg.sv
// Shared constants, command encoding and field-offset helpers for the gen2 IO tile.
// Defaults describe the 4-pin / 6-wire tile; the offset helpers also accept other sizes.
package io_tile_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

  localparam int IO_COUNT_DEF = 4;
  localparam int IC_COUNT_DEF = 6;
  localparam int SEL_IC       = clog2(IC_COUNT_DEF);
  localparam int SEL_IO       = clog2(IO_COUNT_DEF);
  localparam int CONFIG_WIDTH = IO_COUNT_DEF * (SEL_IC + 2) + IC_COUNT_DEF * (SEL_IO + 1);

  // Encoded as {commit, enable}.
  typedef enum logic [1:0] {
    CMD_IDLE   = 2'b00,
    CMD_SHIFT  = 2'b01,
    CMD_COMMIT = 2'b10,
    CMD_BOTH   = 2'b11
  } cfg_cmd_e;

  function automatic int pin_offset(input int i, input int sel_ic = SEL_IC);
    return i * (sel_ic + 2);
  endfunction

  function automatic int wire_offset(input int j, input int io_count = IO_COUNT_DEF,
                                     input int sel_ic = SEL_IC, input int sel_io = SEL_IO);
    return io_count * (sel_ic + 2) + j * (sel_io + 1);
  endfunction

endpackage

// File: rtl/io_tile_gen2_if.sv
// Pad and interconnect data bundle of one IO tile.
interface io_tile_gen2_if #(
  parameter int IO_COUNT = 4,
  parameter int IC_COUNT = 6
);
  logic [IO_COUNT-1:0] data_from_io;
  logic [IO_COUNT-1:0] data_to_io;
  logic [IO_COUNT-1:0] data_to_io_oe;
  logic [IC_COUNT-1:0] data_from_ic;
  logic [IC_COUNT-1:0] data_to_ic;

  modport master (
    output data_from_io, data_from_ic,
    input  data_to_io, data_to_io_oe, data_to_ic
  );

  modport slave (
    input  data_from_io, data_from_ic,
    output data_to_io, data_to_io_oe, data_to_ic
  );
endinterface

// File: rtl/io_tile_config_chain.sv
// Double-buffered configuration chain: serial shift register, bit counter and
// committed active configuration with frame-length checking.
module io_tile_config_chain
  import io_tile_pkg::*;
#(
  parameter int W = CONFIG_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         config_in_i,
  input  logic         config_enable_i,
  input  logic         config_commit_i,
  output logic         config_out_o,
  output logic         config_valid_o,
  output logic         config_error_o,
  output logic [W-1:0] active_cfg_o
);

  localparam int            CW       = clog2(W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);

  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  cfg_q, cfg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  cfg_cmd_e      cmd_s;

  assign cmd_s = cfg_cmd_e'({config_commit_i, config_enable_i});

  // Next-state decode for shift, commit and the rejected commit-while-shifting case.
  always_comb begin
    shift_d = shift_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    error_d = error_q;
    case (cmd_s)
      CMD_SHIFT: begin
        shift_d = {shift_q[W-2:0], config_in_i};
        cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
      end
      CMD_COMMIT: begin
        if (cnt_q == CNT_FULL) begin
          cfg_d   = shift_q;
          valid_d = 1'b1;
          error_d = 1'b0;
        end else begin
          error_d = 1'b1;
        end
        cnt_d = '0;
      end
      CMD_BOTH: begin
        // The bit still enters the chain and starts the next frame's count.
        shift_d = {shift_q[W-2:0], config_in_i};
        cnt_d   = CW'(1);
        error_d = 1'b1;
      end
      default: begin
        shift_d = shift_q;
      end
    endcase
  end

  // Configuration state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      cfg_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign config_out_o   = shift_q[W-1];
  assign config_valid_o = valid_q;
  assign config_error_o = error_q;
  assign active_cfg_o   = cfg_q;

endmodule

// File: rtl/io_tile_gen2.sv
// IO tile: configuration chain plus pad/interconnect crossbar with optional
// per-route output register and per-pin output enable.
module io_tile_gen2
  import io_tile_pkg::*;
#(
  parameter int IO_COUNT = 4,
  parameter int IC_COUNT = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         config_in,
  output logic         config_out,
  input  logic         config_enable,
  input  logic         config_commit,
  output logic         config_valid,
  output logic         config_error,
  io_tile_gen2_if.slave bus
);

  localparam int TILE_SEL_IC = clog2(IC_COUNT);
  localparam int TILE_SEL_IO = clog2(IO_COUNT);
  localparam int TILE_W      = IO_COUNT * (TILE_SEL_IC + 2) + IC_COUNT * (TILE_SEL_IO + 1);

  logic [TILE_W-1:0] active_cfg_s;

  io_tile_config_chain #(.W(TILE_W)) u_chain (
    .clock           (clock),
    .reset           (reset),
    .config_in_i     (config_in),
    .config_enable_i (config_enable),
    .config_commit_i (config_commit),
    .config_out_o    (config_out),
    .config_valid_o  (config_valid),
    .config_error_o  (config_error),
    .active_cfg_o    (active_cfg_s)
  );

  for (genvar i = 0; i < IO_COUNT; i++) begin : g_pin
    localparam int OFF = pin_offset(i, TILE_SEL_IC);
    logic [TILE_SEL_IC-1:0] sel_s;
    logic                   reg_s, oe_s, mux_s, route_d, route_q;

    assign sel_s   = active_cfg_s[OFF +: TILE_SEL_IC];
    assign reg_s   = active_cfg_s[OFF + TILE_SEL_IC];
    assign oe_s    = active_cfg_s[OFF + TILE_SEL_IC + 1];
    assign route_d = mux_s;

    // Interconnect-to-pad select; an unmatched selector leaves the output at 0.
    always_comb begin
      mux_s = 1'b0;
      for (int k = 0; k < IC_COUNT; k++) begin
        mux_s = mux_s | ((sel_s == TILE_SEL_IC'(k)) & bus.data_from_ic[k]);
      end
    end

    // Route flop samples every cycle so switching the reg bit never exposes stale data.
    always_ff @(posedge clock) begin
      if (reset) begin
        route_q <= 1'b0;
      end else begin
        route_q <= route_d;
      end
    end

    assign bus.data_to_io[i]    = config_valid & (reg_s ? route_q : mux_s);
    assign bus.data_to_io_oe[i] = config_valid & oe_s;
  end

  for (genvar j = 0; j < IC_COUNT; j++) begin : g_wire
    localparam int OFF = wire_offset(j, IO_COUNT, TILE_SEL_IC, TILE_SEL_IO);
    logic [TILE_SEL_IO-1:0] sel_s;
    logic                   reg_s, mux_s, route_d, route_q;

    assign sel_s   = active_cfg_s[OFF +: TILE_SEL_IO];
    assign reg_s   = active_cfg_s[OFF + TILE_SEL_IO];
    assign route_d = mux_s;

    // Pad-to-interconnect select.
    always_comb begin
      mux_s = 1'b0;
      for (int k = 0; k < IO_COUNT; k++) begin
        mux_s = mux_s | ((sel_s == TILE_SEL_IO'(k)) & bus.data_from_io[k]);
      end
    end

    // Route flop for the registered interconnect path.
    always_ff @(posedge clock) begin
      if (reset) begin
        route_q <= 1'b0;
      end else begin
        route_q <= route_d;
      end
    end

    assign bus.data_to_ic[j] = config_valid & (reg_s ? route_q : mux_s);
  end

endmodule

// File: tb/tb_io_tile_gen2.sv
// Scoreboard bench for io_tile_gen2: two chained tiles, frame-length checks,
// registered/combinational routing and mid-shift reset.
module tb_io_tile_gen2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, config_in, config_enable, config_commit;
  logic config_out, config_valid, config_error;
  logic en1, out1, valid1, err1;

  io_tile_gen2_if #(.IO_COUNT(4), .IC_COUNT(6)) tif ();
  io_tile_gen2_if #(.IO_COUNT(4), .IC_COUNT(6)) tif1 ();

  io_tile_gen2 #(.IO_COUNT(4), .IC_COUNT(6)) dut (
    .clock(clock), .reset(reset), .config_in(config_in), .config_out(config_out),
    .config_enable(config_enable), .config_commit(config_commit),
    .config_valid(config_valid), .config_error(config_error), .bus(tif.slave)
  );

  io_tile_gen2 #(.IO_COUNT(4), .IC_COUNT(6)) dut1 (
    .clock(clock), .reset(reset), .config_in(config_out), .config_out(out1),
    .config_enable(en1), .config_commit(config_commit),
    .config_valid(valid1), .config_error(err1), .bus(tif1.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // Frame layout: pin i at i*5 {oe,reg,sel[2:0]}, wire j at 20+j*3 {reg,sel[1:0]}.
  function automatic logic [63:0] pin_f(input int i, input logic [2:0] sel, input logic r, input logic oe);
    logic [63:0] v;
    v = 64'd0;
    v[i*5 +: 3] = sel;
    v[i*5 + 3]  = r;
    v[i*5 + 4]  = oe;
    return v;
  endfunction

  function automatic logic [63:0] wire_f(input int j, input logic [1:0] sel, input logic r);
    logic [63:0] v;
    v = 64'd0;
    v[20 + j*3 +: 2] = sel;
    v[20 + j*3 + 2]  = r;
    return v;
  endfunction

  function automatic logic [3:0] m_to_io(input logic [63:0] c, input logic [5:0] ic);
    logic [3:0] r;
    logic [2:0] s;
    r = 4'd0;
    for (int i = 0; i < 4; i++) begin
      s = c[i*5 +: 3];
      r[i] = (s < 3'd6) && ic[s];
    end
    return r;
  endfunction

  function automatic logic [3:0] m_oe(input logic [63:0] c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = c[i*5 + 4];
    return r;
  endfunction

  function automatic logic [5:0] m_to_ic(input logic [63:0] c, input logic [3:0] io);
    logic [5:0] r;
    logic [1:0] s;
    for (int j = 0; j < 6; j++) begin
      s = c[20 + j*3 +: 2];
      r[j] = io[s];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic shift_bits(input logic [63:0] f, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      config_in = f[k];
      config_enable = 1'b1;
      tick();
    end
    config_enable = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic commit();
    config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] obs[$];
    string nm[$];
    logic [63:0] e;
    reset = 1'b1;
    config_in = 1'b1; config_enable = 1'b1; config_commit = 1'b1; en1 = 1'b1;
    tif.data_from_io = 4'hF; tif.data_from_ic = 6'h3F;
    tif1.data_from_io = 4'hF; tif1.data_from_ic = 6'h3F;
    tick(); tick();
    exp_q.push_back(64'd0); obs.push_back(64'(tif.data_to_io));    nm.push_back("rst_to_io");
    exp_q.push_back(64'd0); obs.push_back(64'(tif.data_to_io_oe)); nm.push_back("rst_oe");
    exp_q.push_back(64'd0); obs.push_back(64'(tif.data_to_ic));    nm.push_back("rst_to_ic");
    exp_q.push_back(64'd0); obs.push_back(64'(config_valid));      nm.push_back("rst_valid");
    exp_q.push_back(64'd0); obs.push_back(64'(config_error));      nm.push_back("rst_error");
    exp_q.push_back(64'd0); obs.push_back(64'(config_out));        nm.push_back("rst_cfg_out");
    exp_q.push_back(64'd0); obs.push_back(64'(tif1.data_to_io));   nm.push_back("rst_to_io_t1");
    config_in = 1'b0; config_enable = 1'b0; config_commit = 1'b0; en1 = 1'b0;
    tif.data_from_io = 4'h0; tif.data_from_ic = 6'h00;
    tif1.data_from_io = 4'h0; tif1.data_from_ic = 6'h00;
    reset = 1'b0;
    tick();
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s got %0h exp %0h", nm[k], obs[k], e); end
    end
  endtask

  logic [63:0] cur_cfg;

  task automatic test_valid_frame();
    logic [63:0] obs[$];
    string nm[$];
    logic [63:0] e;
    logic [5:0] pats[3];
    pats[0] = 6'b000100; pats[1] = 6'b000000; pats[2] = 6'b111011;
    cur_cfg = pin_f(0, 3'd2, 1'b0, 1'b1);
    shift_bits(cur_cfg, 38);
    commit();
    exp_q.push_back(64'd1); obs.push_back(64'(config_valid)); nm.push_back("vf_valid");
    exp_q.push_back(64'd0); obs.push_back(64'(config_error)); nm.push_back("vf_error");
    for (int p = 0; p < 3; p++) begin
      tif.data_from_ic = pats[p];
      tif.data_from_io = 4'b0001;
      #1;
      exp_q.push_back(64'(m_to_io(cur_cfg, pats[p]))); obs.push_back(64'(tif.data_to_io)); nm.push_back("vf_to_io");
      exp_q.push_back(64'(m_oe(cur_cfg)));             obs.push_back(64'(tif.data_to_io_oe)); nm.push_back("vf_oe");
      exp_q.push_back(64'(m_to_ic(cur_cfg, 4'b0001))); obs.push_back(64'(tif.data_to_ic)); nm.push_back("vf_to_ic");
    end
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s got %0h exp %0h", nm[k], obs[k], e); end
    end
  endtask

  task automatic test_bad_frames();
    logic [63:0] obs[$];
    string nm[$];
    logic [63:0] e;
    logic [63:0] fb;
    int lens[2];
    lens[0] = 37; lens[1] = 40;
    fb = pin_f(0, 3'd5, 1'b0, 1'b0);
    tif.data_from_ic = 6'b000100;
    for (int l = 0; l < 2; l++) begin
      shift_bits(fb, lens[l]);
      commit();
      exp_q.push_back(64'd1); obs.push_back(64'(config_error)); nm.push_back("bad_error");
      exp_q.push_back(64'd1); obs.push_back(64'(config_valid)); nm.push_back("bad_valid_kept");
      exp_q.push_back(64'(m_to_io(cur_cfg, 6'b000100))); obs.push_back(64'(tif.data_to_io)); nm.push_back("bad_to_io_kept");
      exp_q.push_back(64'(m_oe(cur_cfg))); obs.push_back(64'(tif.data_to_io_oe)); nm.push_back("bad_oe_kept");
    end
    shift_bits(fb, 38);
    commit();
    cur_cfg = fb;
    tif.data_from_ic = 6'b100000;
    #1;
    exp_q.push_back(64'd0); obs.push_back(64'(config_error)); nm.push_back("good_clears_error");
    exp_q.push_back(64'(m_to_io(cur_cfg, 6'b100000))); obs.push_back(64'(tif.data_to_io)); nm.push_back("good_to_io");
    exp_q.push_back(64'(m_oe(cur_cfg))); obs.push_back(64'(tif.data_to_io_oe)); nm.push_back("good_oe");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s got %0h exp %0h", nm[k], obs[k], e); end
    end
  endtask

  task automatic test_registered();
    logic [63:0] obs[$];
    string nm[$];
    logic [63:0] e;
    cur_cfg = wire_f(3, 2'd1, 1'b1) | wire_f(0, 2'd1, 1'b0) |
              pin_f(0, 3'd7, 1'b0, 1'b1) | pin_f(1, 3'd6, 1'b0, 1'b1);
    shift_bits(cur_cfg, 38);
    commit();
    tif.data_from_ic = 6'h3F;
    tif.data_from_io = 4'b0000;
    tick(); tick();
    exp_q.push_back(64'h0000_0000_0000_000C); obs.push_back(64'(tif.data_to_io));    nm.push_back("oor_to_io");
    exp_q.push_back(64'h0000_0000_0000_0003); obs.push_back(64'(tif.data_to_io_oe)); nm.push_back("oor_oe");
    tif.data_from_io = 4'b0010;
    #1;
    exp_q.push_back(64'h0000_0000_0000_0001); obs.push_back(64'(tif.data_to_ic)); nm.push_back("reg_rise_same_cycle");
    tick();
    exp_q.push_back(64'h0000_0000_0000_0009); obs.push_back(64'(tif.data_to_ic)); nm.push_back("reg_rise_next_cycle");
    tif.data_from_io = 4'b0000;
    #1;
    exp_q.push_back(64'h0000_0000_0000_0008); obs.push_back(64'(tif.data_to_ic)); nm.push_back("reg_fall_same_cycle");
    tick();
    exp_q.push_back(64'h0000_0000_0000_0000); obs.push_back(64'(tif.data_to_ic)); nm.push_back("reg_fall_next_cycle");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s got %0h exp %0h", nm[k], obs[k], e); end
    end
  endtask

  task automatic test_commit_enable();
    logic [63:0] obs[$];
    string nm[$];
    logic [63:0] e;
    logic [63:0] fc;
    fc = pin_f(3, 3'd4, 1'b0, 1'b1) | wire_f(5, 2'd3, 1'b0);
    config_in = fc[37];
    config_enable = 1'b1;
    config_commit = 1'b1;
    tick();
    config_enable = 1'b0;
    config_commit = 1'b0;
    exp_q.push_back(64'd1); obs.push_back(64'(config_error)); nm.push_back("both_error");
    exp_q.push_back(64'(m_oe(cur_cfg))); obs.push_back(64'(tif.data_to_io_oe)); nm.push_back("both_cfg_kept");
    shift_bits(fc, 37);
    commit();
    cur_cfg = fc;
    tif.data_from_ic = 6'b010000;
    tif.data_from_io = 4'b1000;
    #1;
    exp_q.push_back(64'd0); obs.push_back(64'(config_error)); nm.push_back("both_then_37_accept");
    exp_q.push_back(64'(m_oe(cur_cfg))); obs.push_back(64'(tif.data_to_io_oe)); nm.push_back("both_new_oe");
    exp_q.push_back(64'(m_to_io(cur_cfg, 6'b010000))); obs.push_back(64'(tif.data_to_io)); nm.push_back("both_new_to_io");
    exp_q.push_back(64'(m_to_ic(cur_cfg, 4'b1000))); obs.push_back(64'(tif.data_to_ic)); nm.push_back("both_new_to_ic");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s got %0h exp %0h", nm[k], obs[k], e); end
    end
  endtask

  task automatic test_chain();
    logic [63:0] obs[$];
    string nm[$];
    logic [63:0] e;
    logic [63:0] fa, fb;
    logic sq[$];
    logic b, want;
    fa = pin_f(1, 3'd3, 1'b0, 1'b1) | wire_f(2, 2'd2, 1'b0);
    fb = pin_f(2, 3'd4, 1'b0, 1'b1) | wire_f(1, 2'd3, 1'b0);
    for (int p = 0; p < 76; p++) begin
      b = (p < 38) ? fb[37 - p] : fa[75 - p];
      config_in = b;
      config_enable = 1'b1;
      en1 = (p >= 38);
      config_commit = (p == 38);
      sq.push_back(b);
      tick();
      if (sq.size() == 38) begin
        want = sq.pop_front(); checks++;
        if (config_out !== want) begin
          errors++; $display("FAIL chain_cfg_out shift %0d got %0b exp %0b", p + 1, config_out, want);
        end
      end
    end
    config_enable = 1'b0; en1 = 1'b0; config_commit = 1'b0; config_in = 1'b0;
    exp_q.push_back(64'(fb[37])); obs.push_back(64'(out1)); nm.push_back("chain_t1_cfg_out");
    commit();
    cur_cfg = fa;
    tif.data_from_ic = 6'b011000;  tif.data_from_io = 4'b0100;
    tif1.data_from_ic = 6'b011000; tif1.data_from_io = 4'b1000;
    #1;
    exp_q.push_back(64'd0); obs.push_back(64'(config_error)); nm.push_back("chain_t0_error");
    exp_q.push_back(64'd1); obs.push_back(64'(valid1));       nm.push_back("chain_t1_valid");
    exp_q.push_back(64'd0); obs.push_back(64'(err1));         nm.push_back("chain_t1_error");
    exp_q.push_back(64'(m_to_io(fa, 6'b011000))); obs.push_back(64'(tif.data_to_io));  nm.push_back("chain_t0_to_io");
    exp_q.push_back(64'(m_oe(fa)));               obs.push_back(64'(tif.data_to_io_oe)); nm.push_back("chain_t0_oe");
    exp_q.push_back(64'(m_to_ic(fa, 4'b0100)));   obs.push_back(64'(tif.data_to_ic));  nm.push_back("chain_t0_to_ic");
    exp_q.push_back(64'(m_to_io(fb, 6'b011000))); obs.push_back(64'(tif1.data_to_io)); nm.push_back("chain_t1_to_io");
    exp_q.push_back(64'(m_oe(fb)));               obs.push_back(64'(tif1.data_to_io_oe)); nm.push_back("chain_t1_oe");
    exp_q.push_back(64'(m_to_ic(fb, 4'b1000)));   obs.push_back(64'(tif1.data_to_ic)); nm.push_back("chain_t1_to_ic");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s got %0h exp %0h", nm[k], obs[k], e); end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] obs[$];
    string nm[$];
    logic [63:0] e;
    logic [63:0] fd;
    logic co_or;
    shift_bits(64'hFFFF_FFFF_FFFF_FFFF, 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tif.data_from_ic = 6'h3F;
    #1;
    exp_q.push_back(64'd0); obs.push_back(64'(config_valid));      nm.push_back("mid_rst_valid");
    exp_q.push_back(64'd0); obs.push_back(64'(config_error));      nm.push_back("mid_rst_error");
    exp_q.push_back(64'd0); obs.push_back(64'(tif.data_to_io_oe)); nm.push_back("mid_rst_oe_forced");
    exp_q.push_back(64'd0); obs.push_back(64'(tif.data_to_io));    nm.push_back("mid_rst_to_io_forced");
    fd = pin_f(0, 3'd1, 1'b1, 1'b1);
    co_or = 1'b0;
    for (int k = 37; k >= 0; k--) begin
      config_in = fd[k];
      config_enable = 1'b1;
      tick();
      if (k > 0) co_or = co_or | config_out;
    end
    config_enable = 1'b0;
    exp_q.push_back(64'd0); obs.push_back(64'(co_or)); nm.push_back("mid_rst_shift_reg_clear");
    tif.data_from_ic = 6'b000000;
    commit();
    exp_q.push_back(64'd1); obs.push_back(64'(config_valid)); nm.push_back("mid_rst_cnt_clear_valid");
    exp_q.push_back(64'd0); obs.push_back(64'(config_error)); nm.push_back("mid_rst_cnt_clear_error");
    tif.data_from_ic = 6'b000010;
    #1;
    exp_q.push_back(64'd0); obs.push_back(64'(tif.data_to_io)); nm.push_back("mid_rst_reg_pin_before");
    tick();
    exp_q.push_back(64'd1); obs.push_back(64'(tif.data_to_io)); nm.push_back("mid_rst_reg_pin_after");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s got %0h exp %0h", nm[k], obs[k], e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; config_in = 1'b0; config_enable = 1'b0; config_commit = 1'b0; en1 = 1'b0;
    tif.data_from_io = 4'h0; tif.data_from_ic = 6'h00;
    tif1.data_from_io = 4'h0; tif1.data_from_ic = 6'h00;
    tick();
    test_reset();
    test_valid_frame();
    test_bad_frames();
    test_registered();
    test_commit_enable();
    test_chain();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
